// File: rtl/fb_cpu_v2.sv
// fb_cpu_v2: parametrised accumulator CPU with a wait-state memory handshake and a HALT state.
// Every instruction runs FETCH -> IFETCH -> EXEC [-> MEM]; MemReady stretches IFETCH and MEM.
module fb_cpu_v2 #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    MDROut,
    input  logic                     MemReady,
    output logic [DATA_WIDTH-1:0]    MDRIn,
    output logic                     RAMWr,
    output logic [ADDRESS_WIDTH-1:0] MAR,
    output logic [ADDRESS_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0]    ACC,
    output logic                     Halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_IFETCH = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        OP_LOAD  = 4'd0,
        OP_STORE = 4'd1,
        OP_ADD   = 4'd2,
        OP_SUB   = 4'd3,
        OP_MUL   = 4'd4,
        OP_AND   = 4'd5,
        OP_JMP   = 4'd6,
        OP_JZ    = 4'd7,
        OP_NOP   = 4'd8,
        OP_HALT  = 4'd9,
        OP_OR    = 4'd10,
        OP_XOR   = 4'd11,
        OP_LDI   = 4'd12,
        OP_JNEG  = 4'd13,
        OP_SHL   = 4'd14,
        OP_SHR   = 4'd15
    } opcode_t;

    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state;
    state_t                   state_n;
    logic [DATA_WIDTH-1:0]    ir;
    logic [DATA_WIDTH-1:0]    ir_n;
    logic [ADDRESS_WIDTH-1:0] pc_n;
    logic [DATA_WIDTH-1:0]    acc_n;
    opcode_t                  op;
    logic [ADDRESS_WIDTH-1:0] operand;

    assign op      = opcode_t'(ir[DATA_WIDTH-1 -: 4]);
    assign operand = ir[ADDRESS_WIDTH-1:0];

    // IR bits between the opcode and operand fields carry no meaning.
    logic unused_ir;
    assign unused_ir = ^ir;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            PC    <= '0;
            ir    <= '0;
            ACC   <= '0;
        end else begin
            state <= state_n;
            PC    <= pc_n;
            ir    <= ir_n;
            ACC   <= acc_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = PC;
        ir_n    = ir;
        acc_n   = ACC;
        MAR     = '0;
        RAMWr   = 1'b0;
        MDRIn   = '0;
        Halted  = 1'b0;

        case (state)
            S_FETCH: begin
                MAR     = PC;
                state_n = S_IFETCH;
            end

            S_IFETCH: begin
                MAR = PC;
                if (MemReady) begin
                    ir_n    = MDROut;
                    pc_n    = PC + PC_STEP;
                    state_n = S_EXEC;
                end
            end

            S_EXEC: begin
                state_n = S_FETCH;
                case (op)
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB,
                    OP_MUL, OP_AND, OP_OR, OP_XOR: begin
                        MAR     = operand;
                        state_n = S_MEM;
                    end
                    OP_JMP:  pc_n = operand;
                    OP_JZ:   if (ACC == '0) pc_n = operand;
                    OP_JNEG: if (ACC[DATA_WIDTH-1]) pc_n = operand;
                    OP_HALT: state_n = S_HALTED;
                    OP_LDI:  acc_n = {{(DATA_WIDTH-ADDRESS_WIDTH){1'b0}}, operand};
                    OP_SHL:  acc_n = {ACC[DATA_WIDTH-2:0], 1'b0};
                    OP_SHR:  acc_n = {1'b0, ACC[DATA_WIDTH-1:1]};
                    default: ;
                endcase
            end

            // Address and write data stay put for as long as the RAM stalls.
            S_MEM: begin
                MAR = operand;
                if (op == OP_STORE) begin
                    RAMWr = 1'b1;
                    MDRIn = ACC;
                end
                if (MemReady) begin
                    state_n = S_FETCH;
                    case (op)
                        OP_LOAD: acc_n = MDROut;
                        OP_ADD:  acc_n = ACC + MDROut;
                        OP_SUB:  acc_n = ACC - MDROut;
                        OP_MUL:  acc_n = ACC * MDROut;
                        OP_AND:  acc_n = ACC & MDROut;
                        OP_OR:   acc_n = ACC | MDROut;
                        OP_XOR:  acc_n = ACC ^ MDROut;
                        default: ;
                    endcase
                end
            end

            S_HALTED: Halted = 1'b1;

            default: state_n = S_FETCH;
        endcase

        // A reset must silence the memory bus immediately, even mid-store.
        if (rst) begin
            MAR   = '0;
            RAMWr = 1'b0;
            MDRIn = '0;
        end
    end

endmodule

// File: tb/tb_fb_cpu_v2.sv
// Scoreboard bench for fb_cpu_v2: an ISA-level model predicts RAM writes and the halt state,
// a forked monitor compares them as the core presents them; directed runs add cycle-exact checks.
`timescale 1ns/1ps
module tb_fb_cpu_v2;

    localparam int AW     = 6;
    localparam int DW     = 10;
    localparam int AMOD   = 64;
    localparam int DMOD   = 1024;
    localparam int BUDGET = 600;

    typedef struct {
        bit isHalt;
        int addr;
        int data;
    } expect_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          MemReady;
    logic          loadReq;
    logic [DW-1:0] MDROut;
    logic [DW-1:0] MDRIn;
    logic          RAMWr;
    logic [AW-1:0] MAR;
    logic [AW-1:0] PC;
    logic [DW-1:0] ACC;
    logic          Halted;

    logic [DW-1:0] mem   [AMOD];
    logic [DW-1:0] image [AMOD];
    expect_t       expQ  [$];
    int            checks   = 0;
    int            failures = 0;
    int            trMar [BUDGET];
    int            trPc  [BUDGET];
    int            trAcc [BUDGET];
    bit            rdyScript [BUDGET];
    int            modelHaltPc;
    int            modelHaltAcc;

    fb_cpu_v2 #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .MDROut   (MDROut),
        .MemReady (MemReady),
        .MDRIn    (MDRIn),
        .RAMWr    (RAMWr),
        .MAR      (MAR),
        .PC       (PC),
        .ACC      (ACC),
        .Halted   (Halted)
    );

    always #5 clk = ~clk;

    // Single-port RAM: asynchronous read, write committed on an edge with RAMWr and MemReady.
    assign MDROut = mem[MAR];
    always @(posedge clk) begin
        if (loadReq) mem <= image;
        else if (RAMWr && MemReady) mem[MAR] <= MDRIn;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [DW-1:0] ins(input int op, input int a);
        return DW'(op * AMOD + a);
    endfunction

    task automatic clearImage();
        for (int i = 0; i < AMOD; i++) image[i] = '0;
    endtask

    function automatic bit readyFor(input int mode, input int c);
        if (mode == 1) return ($urandom_range(0, 3) != 0);
        if (mode == 2 && c < BUDGET) return rdyScript[c];
        return 1'b1;
    endfunction

    // Instruction-level interpreter: pushes every committed store and the final halt state.
    task automatic modelRun(output int cyc);
        int mm [AMOD];
        int pc, acc, ir, op, a, steps;
        bit halted;
        expect_t e;
        for (int i = 0; i < AMOD; i++) mm[i] = int'(image[i]);
        pc = 0; acc = 0; cyc = 0; halted = 0; steps = 0;
        while (!halted && steps < 2000) begin
            ir = mm[pc];
            pc = (pc + 1) % AMOD;
            op = ir / AMOD;
            a  = ir % AMOD;
            steps++;
            cyc += (op inside {[0:5], 10, 11}) ? 4 : 3;
            case (op)
                0:  acc = mm[a];
                1:  begin
                        mm[a] = acc;
                        e.isHalt = 0; e.addr = a; e.data = acc;
                        expQ.push_back(e);
                    end
                2:  acc = (acc + mm[a]) % DMOD;
                3:  acc = (acc - mm[a] + DMOD) % DMOD;
                4:  acc = (acc * mm[a]) % DMOD;
                5:  acc = acc & mm[a];
                6:  pc = a;
                7:  if (acc == 0) pc = a;
                9:  begin
                        halted = 1;
                        e.isHalt = 1; e.addr = pc; e.data = acc;
                        expQ.push_back(e);
                    end
                10: acc = acc | mm[a];
                11: acc = acc ^ mm[a];
                12: acc = a;
                13: if (acc >= DMOD / 2) pc = a;
                14: acc = (acc * 2) % DMOD;
                15: acc = acc / 2;
                default: ;
            endcase
        end
        modelHaltPc  = pc;
        modelHaltAcc = acc;
    endtask

    task automatic monitor();
        bit haltSeen = 0;
        expect_t e;
        forever begin
            @(negedge clk);
            if (!Halted) haltSeen = 0;
            if (!rst && RAMWr && MemReady) begin
                if (expQ.size() == 0) begin
                    checks++; failures++;
                    $display("[TB] FAIL unexpected write: got addr %0d data %0d, required none", MAR, MDRIn);
                end else if (expQ[0].isHalt) begin
                    checks++; failures++;
                    $display("[TB] FAIL write before halt: got addr %0d data %0d, required halt", MAR, MDRIn);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("write addr", int'(MAR), e.addr);
                    checkOutput("write data", int'(MDRIn), e.data);
                end
            end
            if (!rst && Halted && !haltSeen) begin
                haltSeen = 1;
                if (expQ.size() == 0 || !expQ[0].isHalt) begin
                    checks++; failures++;
                    $display("[TB] FAIL early halt: got Halted=1, required pending %0d items", expQ.size());
                end else begin
                    e = expQ.pop_front();
                    checkOutput("halt PC", int'(PC), e.addr);
                    checkOutput("halt ACC", int'(ACC), e.data);
                end
            end
        end
    endtask

    task automatic applyStimulus(input string name, input int mode, input int expCycles);
        int c;
        bit done;
        rst = 1'b1; loadReq = 1'b1; MemReady = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; loadReq = 1'b0;
        c = 0; done = 0;
        MemReady = readyFor(mode, 0);
        while (!done && c < BUDGET) begin
            @(negedge clk);
            trMar[c] = int'(MAR);
            trPc[c]  = int'(PC);
            trAcc[c] = int'(ACC);
            if (Halted) done = 1;
            else begin
                @(posedge clk); #1;
                c++;
                MemReady = readyFor(mode, c);
            end
        end
        checkOutput({name, " halt reached"}, int'(done), 1);
        if (done) begin
            if (expCycles >= 0) checkOutput({name, " cycles"}, c, expCycles);
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                MemReady = ~MemReady;
                @(negedge clk);
                checkOutput({name, " halted RAMWr"}, int'(RAMWr), 0);
                checkOutput({name, " halted stays"}, int'(Halted), 1);
            end
            checkOutput({name, " halted PC hold"}, int'(PC), modelHaltPc);
        end else begin
            @(negedge clk);
        end
        checkOutput({name, " queue drained"}, expQ.size(), 0);
        expQ.delete();
    endtask

    initial begin
        int mc;
        int mode;
        rst = 1'b1; loadReq = 1'b1; MemReady = 1'b1;
        clearImage();
        fork
            monitor();
        join_none

        @(posedge clk); #1;
        checkOutput("reset PC", int'(PC), 0);
        checkOutput("reset ACC", int'(ACC), 0);
        checkOutput("reset MAR", int'(MAR), 0);
        checkOutput("reset RAMWr", int'(RAMWr), 0);
        checkOutput("reset Halted", int'(Halted), 0);

        // Basic program: LOAD 20, ADD 21, STORE 22, HALT.
        clearImage();
        image[0] = ins(0, 20); image[1] = ins(2, 21); image[2] = ins(1, 22); image[3] = ins(9, 0);
        image[20] = 10'd7; image[21] = 10'd5;
        modelRun(mc);
        applyStimulus("basic", 0, 15);
        checkOutput("basic M22", int'(mem[22]), 12);
        checkOutput("basic PC", int'(PC), 4);

        // Modular wrap on ADD/SUB followed by LDI and shifts.
        clearImage();
        image[0] = ins(0, 20); image[1] = ins(2, 21); image[2] = ins(3, 21); image[3] = ins(12, 63);
        image[4] = ins(14, 0); image[5] = ins(14, 0); image[6] = ins(9, 0);
        image[20] = 10'd1000; image[21] = 10'd100;
        modelRun(mc);
        applyStimulus("wrap", 0, 24);
        checkOutput("wrap ACC after ADD", trAcc[8], 76);
        checkOutput("wrap ACC after SUB", trAcc[12], 1000);
        checkOutput("wrap ACC after LDI", trAcc[15], 63);
        checkOutput("wrap final ACC", int'(ACC), 252);

        // Branches: JZ taken, JZ not taken, JNEG taken.
        clearImage();
        image[0] = ins(12, 0); image[1] = ins(7, 10); image[10] = ins(12, 1); image[11] = ins(7, 20);
        image[12] = ins(0, 40); image[13] = ins(13, 30); image[30] = ins(9, 0); image[40] = 10'd512;
        modelRun(mc);
        applyStimulus("branch", 0, 22);
        checkOutput("branch JZ taken MAR", trMar[6], 10);
        checkOutput("branch JZ fall MAR", trMar[12], 12);
        checkOutput("branch JNEG MAR", trMar[19], 30);
        checkOutput("branch final PC", int'(PC), 31);

        // Wait states: 3 stall cycles in IFETCH and 2 in MEM of a LOAD.
        clearImage();
        image[0] = ins(8, 0); image[1] = ins(0, 20); image[2] = ins(9, 0); image[20] = 10'd333;
        for (int i = 0; i < BUDGET; i++) rdyScript[i] = 1'b1;
        rdyScript[4] = 1'b0; rdyScript[5] = 1'b0; rdyScript[6] = 1'b0;
        rdyScript[9] = 1'b0; rdyScript[10] = 1'b0;
        modelRun(mc);
        applyStimulus("wait", 2, 15);
        for (int i = 3; i <= 7; i++) checkOutput($sformatf("wait MAR fetch c%0d", i), trMar[i], 1);
        for (int i = 8; i <= 11; i++) checkOutput($sformatf("wait MAR mem c%0d", i), trMar[i], 20);
        checkOutput("wait PC held", trPc[6], 1);
        checkOutput("wait PC incr", trPc[8], 2);
        checkOutput("wait ACC held", trAcc[11], 0);
        checkOutput("wait ACC loaded", trAcc[12], 333);

        // PC wrap: NOP at the top address falls through to address 0.
        clearImage();
        image[0] = ins(7, 62); image[62] = ins(12, 1); image[63] = ins(8, 0); image[1] = ins(9, 0);
        modelRun(mc);
        applyStimulus("pcwrap", 0, 15);
        checkOutput("pcwrap MAR top", trMar[7], 63);
        checkOutput("pcwrap MAR zero", trMar[9], 0);
        checkOutput("pcwrap PC zero", trPc[9], 0);

        // Reset asserted during a stalled STORE.
        clearImage();
        image[0] = ins(12, 5); image[1] = ins(1, 40); image[2] = ins(9, 0); image[40] = 10'd777;
        rst = 1'b1; loadReq = 1'b1; MemReady = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; loadReq = 1'b0;
        repeat (6) @(posedge clk);
        #1 MemReady = 1'b0;
        @(negedge clk);
        checkOutput("midstore RAMWr", int'(RAMWr), 1);
        checkOutput("midstore MAR", int'(MAR), 40);
        checkOutput("midstore MDRIn", int'(MDRIn), 5);
        rst = 1'b1;
        #1;
        checkOutput("midstore rst RAMWr", int'(RAMWr), 0);
        checkOutput("midstore rst MAR", int'(MAR), 0);
        checkOutput("midstore rst MDRIn", int'(MDRIn), 0);
        @(posedge clk); #1;
        checkOutput("midstore rst PC", int'(PC), 0);
        checkOutput("midstore rst ACC", int'(ACC), 0);
        rst = 1'b0; MemReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midstore restart MAR", int'(MAR), 1);
        checkOutput("midstore restart ACC", int'(ACC), 5);
        rst = 1'b1;
        checkOutput("midstore M40 intact", int'(mem[40]), 777);

        // Random forward-only programs, alternating zero-wait and random-wait RAM.
        for (int n = 0; n < 24; n++) begin
            int k, op, a;
            clearImage();
            k = $urandom_range(4, 30);
            for (int i = 0; i < k; i++) begin
                do op = $urandom_range(0, 15); while (op == 9);
                if (op == 6 || op == 7 || op == 13) a = $urandom_range(i + 1, k);
                else if (op inside {[0:5], 10, 11}) a = $urandom_range(40, 63);
                else a = $urandom_range(0, 63);
                image[i] = ins(op, a);
            end
            image[k] = ins(9, $urandom_range(0, 63));
            for (int i = 40; i < AMOD; i++) image[i] = DW'($urandom_range(0, DMOD - 1));
            modelRun(mc);
            mode = n % 2;
            applyStimulus($sformatf("rand%0d", n), mode, (mode == 0) ? mc : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
